// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed driver for a six-digit 7-segment clock
// display. Each digit owns a slot of SCAN_DIV clk cycles; the first cycle of
// every slot is a dark guard cycle so the previous digit does not ghost.
// Digits selected in blink_mask flash with a half-period of BLINK_TICKS slots.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, the hours-tens digit is kept dark whenever it holds zero.
//   When undefined, the hours-tens digit behaves like every other digit.

module display_scanner #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_en,
  input  logic [23:0] digits,
  input  logic [5:0]  blink_mask,
  output logic [3:0]  number,
  output logic        ena,
  output logic [5:0]  anode
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [2:0]         IDX_LAST   = 3'd5;

  logic [DIV_W-1:0]   div_cnt;
  logic [2:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               en_q;

  logic               scan_tick;
  logic [2:0]         idx_next;
  logic [BLINK_W-1:0] blink_cnt_next;
  logic               blink_phase_next;
  logic [3:0]         digit_sel;
  logic               mask_sel;
  logic               lead_blank;
  logic               ena_next;

  assign scan_tick = (div_cnt == DIV_LAST);

  // Slot divider: free-running modulo-SCAN_DIV counter, keeps running when dark
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (scan_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Next digit index and blink state, only moving at the end of a slot
  always_comb begin
    idx_next         = idx;
    blink_cnt_next   = blink_cnt;
    blink_phase_next = blink_phase;
    if (scan_tick) begin
      idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_next   = '0;
        blink_phase_next = ~blink_phase;
      end else begin
        blink_cnt_next = blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Digit index and blink counters; these advance regardless of disp_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= 3'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      idx         <= idx_next;
      blink_cnt   <= blink_cnt_next;
      blink_phase <= blink_phase_next;
    end
  end

  // Pick the BCD nibble and blink-mask bit belonging to the upcoming digit
  always_comb begin
    digit_sel = 4'd0;
    mask_sel  = 1'b0;
    case (idx_next)
      3'd0: begin digit_sel = digits[3:0];   mask_sel = blink_mask[0]; end
      3'd1: begin digit_sel = digits[7:4];   mask_sel = blink_mask[1]; end
      3'd2: begin digit_sel = digits[11:8];  mask_sel = blink_mask[2]; end
      3'd3: begin digit_sel = digits[15:12]; mask_sel = blink_mask[3]; end
      3'd4: begin digit_sel = digits[19:16]; mask_sel = blink_mask[4]; end
      3'd5: begin digit_sel = digits[23:20]; mask_sel = blink_mask[5]; end
      default: begin digit_sel = 4'd0; mask_sel = 1'b0; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign lead_blank = (idx_next == IDX_LAST) && (digits[23:20] == 4'd0);
`else
  assign lead_blank = 1'b0;
`endif

  assign ena_next = disp_en & ~(mask_sel & blink_phase_next) & ~lead_blank;

  // Digit value and decoder enable are captured once per slot and then held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number <= 4'd0;
      ena    <= 1'b0;
    end else if (scan_tick) begin
      number <= digit_sel;
      ena    <= ena_next;
    end
  end

  // Registered copy of disp_en so the anodes go dark on the very next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= disp_en;
    end
  end

  // Anode drive: dark during the guard cycle or when disabled, else one low bit
  always_comb begin
    anode = 6'b111111;
    if ((div_cnt != '0) && en_q) begin
      anode = ~(6'b000001 << idx);
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed bench for display_scanner with a cycle-level
// reference model derived from slot arithmetic (slot = ticks mod 6,
// blink phase = (ticks / BLINK_TICKS) mod 2) plus literal checkpoints.

module tb_display_scanner;

  localparam int SD = 4;
  localparam int BT = 6;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB_ON = 1'b1;
`else
  localparam logic LZB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_en = 1'b0;
  logic [23:0] digits = 24'h0;
  logic [5:0]  blink_mask = 6'h0;
  logic [3:0]  number;
  logic        ena;
  logic [5:0]  anode;

  int total = 0;
  int bad   = 0;

  int         m_cyc    = 0;
  logic [3:0] m_number = 4'd0;
  logic       m_ena    = 1'b0;
  logic       m_en_q   = 1'b0;

  display_scanner #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk),
    .rst(rst),
    .disp_en(disp_en),
    .digits(digits),
    .blink_mask(blink_mask),
    .number(number),
    .ena(ena),
    .anode(anode)
  );

  always #5 clk = ~clk;

  // Number of slot ticks completed once the edge following cycle c has happened
  function automatic int ticksAfter(input int c);
    return (c + 1) / SD;
  endfunction

  function automatic logic [3:0] pickDigit(input logic [23:0] d, input int slot);
    logic [23:0] v;
    v = d >> (4 * slot);
    return v[3:0];
  endfunction

  function automatic logic expectEna(input logic en, input logic [5:0] mask,
                                     input logic [23:0] d, input int n);
    int   slot;
    int   phase;
    logic e;
    slot  = n % 6;
    phase = (n / BT) % 2;
    e = en && !(mask[slot] && (phase == 1));
    if (LZB_ON && slot == 5 && d[23:20] == 4'd0) e = 1'b0;
    return e;
  endfunction

  function automatic logic [5:0] expectAnode(input int c, input logic enq);
    logic [5:0] one;
    one = 6'b000001;
    if ((c % SD) == 0 || !enq) return 6'b111111;
    return ~(one << ((c / SD) % 6));
  endfunction

  // Reference model, advanced on each rising edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc    <= 0;
      m_number <= 4'd0;
      m_ena    <= 1'b0;
      m_en_q   <= 1'b0;
    end else begin
      if (((m_cyc + 1) % SD) == 0) begin
        m_number <= pickDigit(digits, ticksAfter(m_cyc) % 6);
        m_ena    <= expectEna(disp_en, blink_mask, digits, ticksAfter(m_cyc));
      end
      m_en_q <= disp_en;
      m_cyc  <= m_cyc + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [5:0] ea;
    ea = expectAnode(m_cyc, m_en_q);
    total++;
    if (number !== m_number || ena !== m_ena || anode !== ea) begin
      bad++;
      $display("[TB] FAIL model@cyc%0d: got number=%h ena=%b anode=%b, want number=%h ena=%b anode=%b",
               m_cyc, number, ena, anode, m_number, m_ena, ea);
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] en,
                             input logic ee, input logic [5:0] ea);
    total++;
    if (number !== en || ena !== ee || anode !== ea) begin
      bad++;
      $display("[TB] FAIL %s: got number=%h ena=%b anode=%b, want number=%h ena=%b anode=%b",
               name, number, ena, anode, en, ee, ea);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] mask, input logic [23:0] d);
    disp_en    = en;
    blink_mask = mask;
    digits     = d;
  endtask

  task automatic stepTo(input int target);
    int guard;
    guard = 0;
    while (m_cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (m_cyc != target) begin
      total++;
      bad++;
      $display("[TB] FAIL stepTo: reached cyc=%0d, want %0d", m_cyc, target);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 6'b000000, 24'h123456);
    repeat (2) @(negedge clk);
    checkOutput("reset_hold", 4'd0, 1'b0, 6'b111111);
    rst = 1'b0;

    // Normal scan
    stepTo(1);  checkOutput("pre_tick",     4'd0, 1'b0, 6'b111110);
    stepTo(4);  checkOutput("slot1_guard",  4'd5, 1'b1, 6'b111111);
    stepTo(5);  checkOutput("slot1",        4'd5, 1'b1, 6'b111101);
    stepTo(9);  checkOutput("slot2",        4'd4, 1'b1, 6'b111011);
    stepTo(21); checkOutput("slot5",        4'd1, 1'b1, 6'b011111);
    stepTo(25); checkOutput("slot0_nomask", 4'd6, 1'b1, 6'b111110);

    // Blinking digits 0 and 1
    applyStimulus(1'b1, 6'b000011, 24'h123456);
    stepTo(29); checkOutput("blink_idx1_dark", 4'd5, 1'b0, 6'b111101);
    stepTo(33); checkOutput("blink_idx2_lit",  4'd4, 1'b1, 6'b111011);
    stepTo(49); checkOutput("blink_idx0_lit",  4'd6, 1'b1, 6'b111110);
    stepTo(53); checkOutput("blink_idx1_lit",  4'd5, 1'b1, 6'b111101);
    stepTo(73); checkOutput("blink_idx0_dark", 4'd6, 1'b0, 6'b111110);
    applyStimulus(1'b1, 6'b000000, 24'h123456);

    // Display disable mid-scan and re-enable
    stepTo(74); applyStimulus(1'b0, 6'b000000, 24'h123456);
    stepTo(75); checkOutput("disable_dark",  4'd6, 1'b0, 6'b111111);
    stepTo(77); checkOutput("disable_scan",  4'd5, 1'b0, 6'b111111);
    stepTo(78); applyStimulus(1'b1, 6'b000000, 24'h123456);
    stepTo(79); checkOutput("reenable",      4'd5, 1'b0, 6'b111101);
    stepTo(81); checkOutput("resume_idx2",   4'd4, 1'b1, 6'b111011);
    stepTo(85); checkOutput("idx3_before_rst", 4'd3, 1'b1, 6'b110111);

    // Asynchronous reset mid-slot
    #1 rst = 1'b1;
    #1 checkOutput("async_rst", 4'd0, 1'b0, 6'b111111);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stepTo(4); checkOutput("post_rst_guard", 4'd5, 1'b1, 6'b111111);
    stepTo(5); checkOutput("post_rst_idx1",  4'd5, 1'b1, 6'b111101);

    // Hours tens holding zero
    applyStimulus(1'b1, 6'b000000, 24'h012345);
    stepTo(17); checkOutput("idx4_digit",  4'd1, 1'b1, 6'b101111);
    stepTo(21); checkOutput("hours_tens0", 4'd0, !LZB_ON, 6'b011111);

    // Non-BCD values pass through
    applyStimulus(1'b1, 6'b000000, 24'hFEDCBA);
    stepTo(25); checkOutput("pass_A", 4'hA, 1'b1, 6'b111110);
    stepTo(45); checkOutput("pass_F", 4'hF, 1'b1, 6'b011111);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal range 2 or more.
REQ-002 Parameter BLINK_TICKS, default 250, digit slots per blink half-period; legal range 1 or more.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 disp_en  input  1  1 = display active, 0 = all digits dark.
REQ-006 digits  input  24  six BCD digits; [3:0] = seconds units … [23:20] = hours tens.
REQ-007 blink_mask  input  6  bit i = 1 makes digit i blink (set mode).
REQ-008 number  output  4  BCD value for the 7-segment decoder.
REQ-009 ena  output  1  decoder enable; 0 forces the segments dark.
REQ-010 anode  output  6  digit select, active-low, one-hot-low; bit i drives digit i.

Function
REQ-011 div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; scan_tick = (div_cnt == SCAN_DIV-1).
REQ-012 On scan_tick, idx SHALL advance 0,1,2,3,4,5 and wrap 5 to 0; it is held otherwise.
REQ-013 On scan_tick, blink_cnt SHALL increment; at BLINK_TICKS-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-014 number SHALL be registered and loaded on scan_tick with digits[4*idx_next +: 4], then held for the whole slot; input changes mid-slot are not visible until the digit's next slot.
REQ-015 ena SHALL be registered and loaded on scan_tick as: disp_en AND NOT (blink_mask[idx_next] AND blink_phase_next).
REQ-016 anode SHALL be 6'b111111 in the cycle where div_cnt == 0 (one-cycle ghosting guard) and ~(1 << idx) in all other cycles of the slot.
REQ-017 When disp_en = 0, anode SHALL be 6'b111111 from the next clk edge; div_cnt, idx and blink counting SHALL continue.
REQ-018 BCD values 10–15 SHALL pass through on number unchanged; blanking them is the decoder's job.
REQ-019 Scan period SHALL be 6*SCAN_DIV clk cycles, and blink full period 2*BLINK_TICKS*SCAN_DIV clk cycles.
REQ-020 blink_mask = 0 SHALL never drop ena for blink reasons, regardless of blink_phase.

Reset
REQ-021 While rst = 1, the block SHALL hold: div_cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0, number = 0, ena = 0, anode = 6'b111111.
REQ-022 An rst assertion mid-slot SHALL take effect immediately, without waiting for clk.
REQ-023 After rst deasserts, the first scan_tick SHALL occur SCAN_DIV cycles later and SHALL select idx 1.
REQ-024 Until that first scan_tick, anode SHALL show digit 0 with ena = 0.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN controls leading-zero blanking of the hours-tens digit.
REQ-026 When defined: in the slot loading idx 5, if digits[23:20] == 0, ena SHALL be 0; the other digits are unaffected.
REQ-027 When undefined: hours tens SHALL display 0 normally, and no logic for this feature is present.

Verification (SCAN_DIV = 4, BLINK_TICKS = 6)
REQ-028 Reset, then digits = 24'h123456, disp_en = 1, mask = 0 -> number sequence 5,4,3,2,1,6 (idx 1..5, 0), each held 4 cycles, anode low bit matches idx, ena = 1.
REQ-029 Anode at every slot start -> anode = 6'b111111 for exactly 1 cycle, then one bit low for 3 cycles.
REQ-030 blink_mask = 6'b000011 -> ena = 0 for idx 0 and 1 during alternate 24-cycle windows; other digits' ena stays 1.
REQ-031 disp_en = 0 mid-scan -> anode = 6'b111111 next edge; re-enable -> scanning resumes at the continuing idx.
REQ-032 rst pulsed while idx = 3 -> outputs take reset values asynchronously; after release, idx 1 is selected 4 cycles later.
REQ-033 digits = 24'h012345 with LEADING_ZERO_BLANK_EN defined -> ena = 0 in the idx 5 slot; same stimulus without the macro -> ena = 1 and number = 0.
